// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter shared definitions:
// opcodes, result word layout, clog2 helper.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_AND    = 2'b10,
    OP_POPCNT = 2'b11
  } alu_op_e;

  localparam int Y_ZERO  = 0;
  localparam int Y_CARRY = 1;
  localparam int Y_OVF   = 2;
  localparam int Y_RES   = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/alu_arbiter_tag_fifo.sv
// tag_fifo: in-order FIFO of requester
// indices for in-flight ALU operations.
module tag_fifo
  import alu_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [W-1:0]                din,
  output logic                        full,
  output logic                        empty,
  output logic [clog2(DEPTH+1)-1:0]   count,
  output logic [W-1:0]                head
);

  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rp];

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= inc(wp);
      if (pop)  rp <= inc(rp);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU
// among NREQ requesters, in-order result return.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int TAG_DEPTH = 2
) (
  input  logic                            i_CLK,
  input  logic                            i_RST,
  input  logic [NREQ-1:0]                 i_REQ_VALID,
  output logic [NREQ-1:0]                 o_REQ_READY,
  input  logic [NREQ*WIDTH-1:0]           i_REQ_ARG0,
  input  logic [NREQ*WIDTH-1:0]           i_REQ_ARG1,
  input  logic [NREQ*2-1:0]               i_REQ_OPER,
  output logic [WIDTH-1:0]                o_ALU_ARG0,
  output logic [WIDTH-1:0]                o_ALU_ARG1,
  output logic [1:0]                      o_ALU_OPER,
  output logic                            o_ALU_VALID,
  input  logic                            i_ALU_READY,
  input  logic [WIDTH+2:0]                i_ALU_Y,
  input  logic                            i_ALU_VALID,
  output logic                            o_ALU_READY,
  output logic [WIDTH+2:0]                o_RSP_Y,
  output logic [NREQ-1:0]                 o_RSP_VALID,
  input  logic [NREQ-1:0]                 i_RSP_READY,
  output logic [clog2(TAG_DEPTH+1)-1:0]   o_INFLIGHT,
  output logic                            o_ERR
);

  localparam int PW = clog2(NREQ);
  localparam int SW = PW + 1;

  logic [WIDTH-1:0] a0 [NREQ];
  logic [WIDTH-1:0] a1 [NREQ];
  logic [1:0]       op [NREQ];

  logic [PW-1:0] ptr;
  logic [PW-1:0] lock_idx;
  logic [PW-1:0] pick;
  logic [PW-1:0] g;
  logic [PW-1:0] head;
  logic [SW-1:0] s;
  logic          lock;
  logic          found;
  logic          any;
  logic          full;
  logic          empty;
  logic          accept;
  logic          stall;
  logic          pop;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      a0[k] = i_REQ_ARG0[k*WIDTH +: WIDTH];
      a1[k] = i_REQ_ARG1[k*WIDTH +: WIDTH];
      op[k] = i_REQ_OPER[k*2 +: 2];
    end
  end

  // first valid requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    s     = '0;
    for (int i = 0; i < NREQ; i++) begin
      s = {1'b0, ptr} + SW'(i);
      if (s >= SW'(NREQ)) s = s - SW'(NREQ);
      if (!found && i_REQ_VALID[s[PW-1:0]]) begin
        found = 1'b1;
        pick  = s[PW-1:0];
      end
    end
  end

  assign g   = lock ? lock_idx : pick;
  assign any = lock ? i_REQ_VALID[lock_idx] : found;

  assign o_ALU_VALID = any & ~full & ~i_RST;
  assign accept      = o_ALU_VALID & i_ALU_READY;
  assign stall       = o_ALU_VALID & ~i_ALU_READY;

  assign o_REQ_READY = accept ? (NREQ'(1) << g) : '0;
  assign o_ALU_ARG0  = o_ALU_VALID ? a0[g] : '0;
  assign o_ALU_ARG1  = o_ALU_VALID ? a1[g] : '0;
  assign o_ALU_OPER  = o_ALU_VALID ? op[g] : '0;

  assign o_RSP_Y     = i_ALU_Y;
  assign o_RSP_VALID = (i_ALU_VALID & ~empty) ?
                       (NREQ'(1) << head) : '0;
  assign o_ALU_READY = i_RSP_READY[head] & ~empty;
  assign pop         = i_ALU_VALID & o_ALU_READY;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      ptr      <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      o_ERR    <= 1'b0;
    end else begin
      if (accept)
        ptr <= (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
      lock <= stall;
      if (stall) lock_idx <= g;
      if (i_ALU_VALID && empty) o_ERR <= 1'b1;
    end
  end

  tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (PW)
  ) u_tags (
    .clk   (i_CLK),
    .rst   (i_RST),
    .push  (accept),
    .pop   (pop),
    .din   (g),
    .full  (full),
    .empty (empty),
    .count (o_INFLIGHT),
    .head  (head)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table plus
// hand sequences around a 1-cycle ALU model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [1:0]  op;
    logic [3:0]  rspv;
    logic [10:0] y;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a0;
  logic [31:0] req_a1;
  logic [7:0]  req_op;
  logic [7:0]  alu_a0;
  logic [7:0]  alu_a1;
  logic [1:0]  alu_op;
  logic        alu_vin;
  logic        alu_rdy;
  logic [10:0] alu_y;
  logic        alu_vout;
  logic        alu_rdy_out;
  logic [10:0] rsp_y;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [1:0]  inflight;
  logic        err;
  logic        inj;

  int checks = 0;
  int errors = 0;
  vec_t tbl [16];

  alu_arbiter #(
    .WIDTH(8), .NREQ(4), .TAG_DEPTH(2)
  ) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_REQ_VALID (req_valid),
    .o_REQ_READY (req_ready),
    .i_REQ_ARG0  (req_a0),
    .i_REQ_ARG1  (req_a1),
    .i_REQ_OPER  (req_op),
    .o_ALU_ARG0  (alu_a0),
    .o_ALU_ARG1  (alu_a1),
    .o_ALU_OPER  (alu_op),
    .o_ALU_VALID (alu_vin),
    .i_ALU_READY (alu_rdy),
    .i_ALU_Y     (alu_y),
    .i_ALU_VALID (alu_vout),
    .o_ALU_READY (alu_rdy_out),
    .o_RSP_Y     (rsp_y),
    .o_RSP_VALID (rsp_valid),
    .i_RSP_READY (rsp_ready),
    .o_INFLIGHT  (inflight),
    .o_ERR       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [10:0] alu_fn(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [1:0] o
  );
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    logic       v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (o)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[7:0]; c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_AND:  r = a & b;
      default: r = 8'($countones(a));
    endcase
    return {r, v, c, (r == 8'h00)};
  endfunction

  // ALU with one register stage and a small result queue
  logic [10:0] aq [4];
  logic [1:0]  aw;
  logic [1:0]  ar;
  logic [2:0]  ac;
  logic        apush;
  logic        apop;

  assign apush    = alu_vin & alu_rdy;
  assign apop     = (ac != 3'd0) & alu_rdy_out;
  assign alu_vout = (ac != 3'd0) | inj;
  assign alu_y    = inj ? 11'h7FF : aq[ar];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw <= '0;
      ar <= '0;
      ac <= '0;
    end else begin
      if (apush) begin
        aq[aw] <= alu_fn(alu_a0, alu_a1, alu_op);
        aw     <= aw + 2'd1;
      end
      if (apop) ar <= ar + 2'd1;
      ac <= ac + 3'(apush) - 3'(apop);
    end
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 4'hF;
    alu_rdy   = 1'b1;
    inj       = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // r0 ADD 05+03, r1 SUB 05-05, r2 ADD 7F+01, r3 AND F0&3C
    req_a0 = {8'hF0, 8'h7F, 8'h05, 8'h05};
    req_a1 = {8'h3C, 8'h01, 8'h05, 8'h03};
    req_op = {2'd2, 2'd0, 2'd1, 2'd0};

    tbl[0]  = '{4'hF, 4'h1, 8'h05, 8'h03, 2'd0, 4'h0, 11'h000};
    tbl[1]  = '{4'hF, 4'h2, 8'h05, 8'h05, 2'd1, 4'h1, 11'h040};
    tbl[2]  = '{4'hF, 4'h4, 8'h7F, 8'h01, 2'd0, 4'h2, 11'h001};
    tbl[3]  = '{4'hF, 4'h8, 8'hF0, 8'h3C, 2'd2, 4'h4, 11'h404};
    tbl[4]  = '{4'hF, 4'h1, 8'h05, 8'h03, 2'd0, 4'h8, 11'h180};
    tbl[5]  = '{4'hF, 4'h2, 8'h05, 8'h05, 2'd1, 4'h1, 11'h040};
    tbl[6]  = '{4'hF, 4'h4, 8'h7F, 8'h01, 2'd0, 4'h2, 11'h001};
    tbl[7]  = '{4'hF, 4'h8, 8'hF0, 8'h3C, 2'd2, 4'h4, 11'h404};
    tbl[8]  = '{4'h0, 4'h0, 8'h00, 8'h00, 2'd0, 4'h8, 11'h180};
    tbl[9]  = '{4'hA, 4'h2, 8'h05, 8'h05, 2'd1, 4'h0, 11'h000};
    tbl[10] = '{4'hA, 4'h8, 8'hF0, 8'h3C, 2'd2, 4'h2, 11'h001};
    tbl[11] = '{4'hB, 4'h1, 8'h05, 8'h03, 2'd0, 4'h8, 11'h180};
    tbl[12] = '{4'h6, 4'h2, 8'h05, 8'h05, 2'd1, 4'h1, 11'h040};
    tbl[13] = '{4'h0, 4'h0, 8'h00, 8'h00, 2'd0, 4'h2, 11'h001};
    tbl[14] = '{4'h1, 4'h1, 8'h05, 8'h03, 2'd0, 4'h0, 11'h000};
    tbl[15] = '{4'h0, 4'h0, 8'h00, 8'h00, 2'd0, 4'h1, 11'h040};

    rst       = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    alu_rdy   = 1'b1;
    inj       = 1'b0;
    #2;
    chk("rst alu_valid", 32'(alu_vin), 0);
    chk("rst req_ready", 32'(req_ready), 0);
    chk("rst inflight", 32'(inflight), 0);
    chk("rst err", 32'(err), 0);
    chk("rst rsp_valid", 32'(rsp_valid), 0);

    // single requester, overflow add
    do_reset();
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t1 alu_valid", 32'(alu_vin), 1);
    chk("t1 req_ready", 32'(req_ready), 32'h4);
    chk("t1 arg0", 32'(alu_a0), 32'h7F);
    chk("t1 arg1", 32'(alu_a1), 32'h01);
    chk("t1 oper", 32'(alu_op), 0);
    nxt();
    req_valid = '0;
    @(negedge clk);
    chk("t1 rsp_valid", 32'(rsp_valid), 32'h4);
    chk("t1 rsp_y", 32'(rsp_y), 32'h404);
    chk("t1 alu_ready", 32'(alu_rdy_out), 1);
    chk("t1 inflight", 32'(inflight), 1);
    nxt();

    // round-robin vector table
    do_reset();
    for (int i = 0; i < 16; i++) begin
      req_valid = tbl[i].valid;
      @(negedge clk);
      chk($sformatf("tbl%0d ready", i),
          32'(req_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d alu_valid", i),
          32'(alu_vin), 32'(|tbl[i].ready));
      chk($sformatf("tbl%0d arg0", i),
          32'(alu_a0), 32'(tbl[i].a0));
      chk($sformatf("tbl%0d arg1", i),
          32'(alu_a1), 32'(tbl[i].a1));
      chk($sformatf("tbl%0d oper", i),
          32'(alu_op), 32'(tbl[i].op));
      chk($sformatf("tbl%0d rsp_valid", i),
          32'(rsp_valid), 32'(tbl[i].rspv));
      chk($sformatf("tbl%0d alu_ready", i),
          32'(alu_rdy_out), 32'(|tbl[i].rspv));
      if (tbl[i].rspv != 4'h0)
        chk($sformatf("tbl%0d rsp_y", i),
            32'(rsp_y), 32'(tbl[i].y));
      nxt();
    end

    // grant lock while the ALU stalls
    do_reset();
    alu_rdy   = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("t3 a valid", 32'(alu_vin), 1);
    chk("t3 a ready", 32'(req_ready), 0);
    chk("t3 a arg0", 32'(alu_a0), 32'h05);
    nxt();
    req_valid = 4'b0011;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("t3 hold%0d oper", c), 32'(alu_op), 1);
      chk($sformatf("t3 hold%0d arg1", c), 32'(alu_a1), 32'h05);
      chk($sformatf("t3 hold%0d ready", c), 32'(req_ready), 0);
      nxt();
    end
    alu_rdy = 1'b1;
    @(negedge clk);
    chk("t3 accept", 32'(req_ready), 32'h2);
    nxt();
    req_valid = 4'b1101;
    @(negedge clk);
    chk("t3 g2", 32'(req_ready), 32'h4);
    chk("t3 rsp1", 32'(rsp_valid), 32'h2);
    chk("t3 rsp1 y", 32'(rsp_y), 32'h001);
    nxt();
    @(negedge clk);
    chk("t3 g3", 32'(req_ready), 32'h8);
    chk("t3 rsp2 y", 32'(rsp_y), 32'h404);
    nxt();
    @(negedge clk);
    chk("t3 g0", 32'(req_ready), 32'h1);
    chk("t3 rsp3", 32'(rsp_valid), 32'h8);
    nxt();

    // full tag FIFO backpressure
    do_reset();
    rsp_ready = 4'b1110;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t4 c1 ready", 32'(req_ready), 32'h1);
    chk("t4 c1 inflight", 32'(inflight), 0);
    nxt();
    @(negedge clk);
    chk("t4 c2 ready", 32'(req_ready), 32'h1);
    chk("t4 c2 inflight", 32'(inflight), 1);
    chk("t4 c2 rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t4 c2 alu_ready", 32'(alu_rdy_out), 0);
    nxt();
    req_valid = 4'hF;
    @(negedge clk);
    chk("t4 c3 alu_valid", 32'(alu_vin), 0);
    chk("t4 c3 ready", 32'(req_ready), 0);
    chk("t4 c3 inflight", 32'(inflight), 2);
    chk("t4 c3 arg0", 32'(alu_a0), 0);
    nxt();
    rsp_ready = 4'hF;
    @(negedge clk);
    chk("t4 c4 alu_valid", 32'(alu_vin), 0);
    chk("t4 c4 rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t4 c4 rsp_y", 32'(rsp_y), 32'h040);
    chk("t4 c4 alu_ready", 32'(alu_rdy_out), 1);
    chk("t4 c4 inflight", 32'(inflight), 2);
    nxt();
    @(negedge clk);
    chk("t4 c5 ready", 32'(req_ready), 32'h2);
    chk("t4 c5 inflight", 32'(inflight), 1);
    chk("t4 c5 rsp_valid", 32'(rsp_valid), 32'h1);
    nxt();
    req_valid = '0;
    @(negedge clk);
    chk("t4 c6 inflight", 32'(inflight), 1);
    chk("t4 c6 rsp_valid", 32'(rsp_valid), 32'h2);
    chk("t4 c6 rsp_y", 32'(rsp_y), 32'h001);
    nxt();
    @(negedge clk);
    chk("t4 c7 inflight", 32'(inflight), 0);
    chk("t4 c7 rsp_valid", 32'(rsp_valid), 0);
    nxt();

    // stray ALU result with no tag held
    do_reset();
    inj = 1'b1;
    @(negedge clk);
    chk("t5 rsp_valid", 32'(rsp_valid), 0);
    chk("t5 alu_ready", 32'(alu_rdy_out), 0);
    chk("t5 err early", 32'(err), 0);
    nxt();
    inj = 1'b0;
    @(negedge clk);
    chk("t5 err set", 32'(err), 1);
    nxt();
    nxt();
    @(negedge clk);
    chk("t5 err held", 32'(err), 1);
    nxt();

    // asynchronous reset with two tags in flight
    do_reset();
    rsp_ready = '0;
    req_valid = 4'b0011;
    @(negedge clk);
    chk("t6 g0", 32'(req_ready), 32'h1);
    nxt();
    @(negedge clk);
    chk("t6 g1", 32'(req_ready), 32'h2);
    nxt();
    chk("t6 pre inflight", 32'(inflight), 2);
    #2 rst = 1'b1;
    #1;
    chk("t6 alu_valid", 32'(alu_vin), 0);
    chk("t6 req_ready", 32'(req_ready), 0);
    chk("t6 rsp_valid", 32'(rsp_valid), 0);
    chk("t6 alu_ready", 32'(alu_rdy_out), 0);
    chk("t6 inflight", 32'(inflight), 0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    #1;
    chk("t6 post g0", 32'(req_ready), 32'h1);
    chk("t6 post rsp", 32'(rsp_valid), 0);
    nxt();
    @(negedge clk);
    chk("t6 post g1", 32'(req_ready), 32'h2);
    chk("t6 post rsp0", 32'(rsp_valid), 32'h1);
    nxt();
    req_valid = '0;
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
